// File: rtl/sdp_ram_scrub_pkg.sv
// rtl/sdp_ram_scrub_pkg.sv - shared types and byte-lane merge helper for sdp_ram_scrub
//
// Purpose: FSM state type and the lane_merge function used by both the storage
//          write path and the read collision forwarding path.
// Ports:   none (package)
// Build:   optional macro SDP_RAM_SCRUB_OUTPUT_REG_EN is consumed by rtl/sdp_ram_scrub.sv
package sdp_ram_scrub_pkg;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} sdp_ram_state_e;

  // Packages cannot be parameterised, so lane_merge works on a fixed maximum
  // width. Callers zero-extend their words and byte enables to this width and
  // keep the low DATA_WIDTH bits of the result. DATA_WIDTH must not exceed it.
  localparam int LANE_MERGE_W  = 256;
  localparam int LANE_MERGE_IW = 8;

  // Bit i takes new_word when its lane (i / byte_w) is enabled, else old_word.
  function automatic logic [LANE_MERGE_W-1:0] lane_merge(
    input logic [LANE_MERGE_W-1:0] old_word,
    input logic [LANE_MERGE_W-1:0] new_word,
    input logic [LANE_MERGE_W-1:0] be,
    input int unsigned             byte_w
  );
    logic [LANE_MERGE_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < LANE_MERGE_W; i++) begin
      if (be[LANE_MERGE_IW'(32'(i) / byte_w)]) begin
        merged[LANE_MERGE_IW'(i)] = new_word[LANE_MERGE_IW'(i)];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sdp_ram_scrub_array.sv
// rtl/sdp_ram_scrub_array.sv - bare simple dual-port storage with byte-lane writes
//
// Purpose: DEPTH x DATA_WIDTH storage, one write port with per-lane enables and
//          one registered read port (address sampled on the read edge,
//          read-first on a same-address write). Storage itself is not reset.
// Ports:
//   clk_i      in   clock
//   rst_ni     in   asynchronous active-low reset (read data register only)
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write address
//   wr_data_i  in   write data
//   wr_be_i    in   per-lane write enables
//   rd_en_i    in   read strobe
//   rd_addr_i  in   read address
//   rd_data_o  out  registered read data, holds between reads
module sdp_ram_scrub_array
  import sdp_ram_scrub_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             wr_en_i,
  input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0]            wr_data_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be_i,
  input  logic                             rd_en_i,
  input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
  output logic [DATA_WIDTH-1:0]            rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [LANE_MERGE_W-1:0] wr_merge_full;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic                    unused_wr_merge;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  assign wr_merge_full = lane_merge(LANE_MERGE_W'(mem[wr_addr_i]),
                                    LANE_MERGE_W'(wr_data_i),
                                    LANE_MERGE_W'(wr_be_i),
                                    BYTE_WIDTH);
  assign wr_word         = wr_merge_full[DATA_WIDTH-1:0];
  assign unused_wr_merge = ^wr_merge_full;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_word;
    end
  end

  // Samples the pre-write contents on a same-address collision; the top level
  // forwards the write lanes on top of this.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sdp_ram_scrub.sv
// rtl/sdp_ram_scrub.sv - simple dual-port RAM with byte enables, forwarding and clear engine
//
// Purpose: single-clock SDP RAM. After reset or on init_req the clear engine
//          writes INIT_VALUE to every entry, one per cycle; both ports are
//          ignored meanwhile. Reads have latency 1 (2 with the output stage),
//          same-edge same-address read/write returns the merged write data.
// Build macro: SDP_RAM_SCRUB_OUTPUT_REG_EN adds an output register stage.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   write strobe
//   wr_addr    in   write address
//   wr_data    in   write data
//   wr_be      in   per-lane write enables
//   rd_en      in   read strobe
//   rd_addr    in   read address
//   rd_data    out  read data, holds between reads
//   rd_valid   out  one-cycle pulse per accepted read
//   init_req   in   request a full re-clear (honoured only when idle)
//   init_busy  out  clear engine active
module sdp_ram_scrub
  import sdp_ram_scrub_pkg::*;
#(
  parameter int                       DATA_WIDTH = 32,
  parameter int                       BYTE_WIDTH = 8,
  parameter int                       ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0]    INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  input  logic                             init_req,
  output logic                             init_busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

  sdp_ram_state_e          state_q, state_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;

  logic                    arr_we;
  logic [ADDR_WIDTH-1:0]   arr_waddr;
  logic [DATA_WIDTH-1:0]   arr_wdata;
  logic [NB-1:0]           arr_wbe;
  logic [DATA_WIDTH-1:0]   arr_rdata;

  logic                    rd_acc;
  logic                    wr_acc;
  logic                    collide;

  logic                    rvalid_q;
  logic                    fwd_q;
  logic [DATA_WIDTH-1:0]   fwd_data_q;
  logic [NB-1:0]           fwd_be_q;

  logic [LANE_MERGE_W-1:0] fwd_merge_full;
  logic                    unused_fwd_merge;
  logic [DATA_WIDTH-1:0]   rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The clear engine owns the write port in CLEAR; user strobes only reach the
  // array in READY, and an init_req edge drops both of them.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_we    = 1'b0;
    arr_waddr = wr_addr;
    arr_wdata = wr_data;
    arr_wbe   = wr_be;
    rd_acc    = 1'b0;
    wr_acc    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = cnt_q[ADDR_WIDTH-1:0];
        arr_wdata = INIT_VALUE;
        arr_wbe   = '1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
        end
      end
      READY: begin
        if (init_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          wr_acc = wr_en;
          rd_acc = rd_en;
          arr_we = wr_en;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign collide   = rd_acc & wr_acc & (rd_addr == wr_addr);
  assign init_busy = (state_q == CLEAR);

  sdp_ram_scrub_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (arr_we),
    .wr_addr_i (arr_waddr),
    .wr_data_i (arr_wdata),
    .wr_be_i   (arr_wbe),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_addr),
    .rd_data_o (arr_rdata)
  );

  // Forwarding state is captured only with an accepted read, so it stays
  // paired with the array read register and rd_word holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      fwd_be_q   <= '0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        fwd_q      <= collide;
        fwd_data_q <= wr_data;
        fwd_be_q   <= wr_be;
      end
    end
  end

  // Array returns the pre-write word on a collision; overlay the written lanes
  // to give write-first behaviour.
  assign fwd_merge_full   = lane_merge(LANE_MERGE_W'(arr_rdata),
                                       LANE_MERGE_W'(fwd_data_q),
                                       LANE_MERGE_W'(fwd_be_q),
                                       BYTE_WIDTH);
  assign unused_fwd_merge = ^fwd_merge_full;
  assign rd_word          = fwd_q ? fwd_merge_full[DATA_WIDTH-1:0] : arr_rdata;

`ifdef SDP_RAM_SCRUB_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;

  // Runs independently of the FSM so a read accepted just before a clear
  // starts still completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rvalid_q;
      if (rvalid_q) begin
        out_data_q <= rd_word;
      end
    end
  end

  assign rd_data  = out_data_q;
  assign rd_valid = out_valid_q;
`else
  assign rd_data  = rd_word;
  assign rd_valid = rvalid_q;
`endif

endmodule
